// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multicycle MIPS datapath.
// Sequences fetch, decode, execute, memory and write-back states, drives all
// datapath selects and write enables, and stalls on mem_ready_i.
// Optional feature macro: MULTICYCLE_JAL_EN adds the JAL state and link_o.
// Handshake: a memory access (FETCH, MEM_READ, MEM_WRITE) holds its request
// asserted and the FSM stays in that state until mem_ready_i is seen high; the
// access completes in the cycle where request and mem_ready_i are both high.
module multicycle_control_fsm #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       pc_write_cond_o,
  output logic       branch_ne_o,
  output logic       i_or_d_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       mem_to_reg_o,
  output logic       reg_dst_o,
  output logic       reg_write_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] pc_source_o,
  output logic [2:0] alu_op_o,
  output logic       illegal_op_o,
`ifdef MULTICYCLE_JAL_EN
  output logic       link_o,
`endif
  output logic [3:0] state_o
);

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_EXEC_R    = 4'd6;
  localparam logic [3:0] S_R_WB      = 4'd7;
  localparam logic [3:0] S_BRANCH    = 4'd8;
  localparam logic [3:0] S_JUMP      = 4'd9;
  localparam logic [3:0] S_EXEC_I    = 4'd10;
  localparam logic [3:0] S_I_WB      = 4'd11;
  localparam logic [3:0] S_JAL       = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic [3:0] decode_target;
  logic       op_known;

  // Opcode dispatch out of DECODE; unknown opcodes fall back to FETCH.
  always_comb begin
    decode_target = S_FETCH;
    op_known      = 1'b1;
    case (opcode_i)
      OP_LW, OP_SW:                   decode_target = S_MEM_ADDR;
      OP_RTYPE:                       decode_target = S_EXEC_R;
      OP_BEQ, OP_BNE:                 decode_target = S_BRANCH;
      OP_J:                           decode_target = S_JUMP;
      OP_ADDI, OP_ORI, OP_ANDI, OP_LUI: decode_target = S_EXEC_I;
`ifdef MULTICYCLE_JAL_EN
      OP_JAL:                         decode_target = S_JAL;
`endif
      default:                        op_known = 1'b0;
    endcase
  end

  // Next-state logic; memory states wait for mem_ready_i.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:     state_d = mem_ready_i ? S_DECODE : S_FETCH;
      S_DECODE:    state_d = decode_target;
      S_MEM_ADDR:  state_d = (opcode_i == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  state_d = mem_ready_i ? S_MEM_WB : S_MEM_READ;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: state_d = mem_ready_i ? S_FETCH : S_MEM_WRITE;
      S_EXEC_R:    state_d = S_R_WB;
      S_R_WB:      state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_JUMP:      state_d = S_FETCH;
      S_EXEC_I:    state_d = S_I_WB;
      S_I_WB:      state_d = S_FETCH;
      default:     state_d = S_FETCH;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= RESET_STATE;
    else        state_q <= state_d;
  end

  // Moore output decode; everything is forced low while reset is held so an
  // interrupted access never sees a stray enable in the reset cycle.
  always_comb begin
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    branch_ne_o     = 1'b0;
    i_or_d_o        = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    ir_write_o      = 1'b0;
    mem_to_reg_o    = 1'b0;
    reg_dst_o       = 1'b0;
    reg_write_o     = 1'b0;
    alu_src_a_o     = 1'b0;
    alu_src_b_o     = 2'b00;
    pc_source_o     = 2'b00;
    alu_op_o        = 3'b000;
    illegal_op_o    = 1'b0;
`ifdef MULTICYCLE_JAL_EN
    link_o          = 1'b0;
`endif
    state_o         = 4'd0;
    if (reset) begin
      state_o = state_q;
      case (state_q)
        S_FETCH: begin
          mem_read_o  = 1'b1;
          alu_src_b_o = 2'b01;
          alu_op_o    = 3'b011;
          ir_write_o  = mem_ready_i;
          pc_write_o  = mem_ready_i;
        end
        S_DECODE: begin
          alu_src_b_o  = 2'b11;
          alu_op_o     = 3'b011;
          illegal_op_o = ~op_known;
        end
        S_MEM_ADDR: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = 2'b10;
          alu_op_o    = 3'b011;
        end
        S_MEM_READ: begin
          mem_read_o = 1'b1;
          i_or_d_o   = 1'b1;
        end
        S_MEM_WB: begin
          reg_write_o  = 1'b1;
          mem_to_reg_o = 1'b1;
        end
        S_MEM_WRITE: begin
          mem_write_o = 1'b1;
          i_or_d_o    = 1'b1;
        end
        S_EXEC_R: begin
          alu_src_a_o = 1'b1;
          alu_op_o    = 3'b111;
        end
        S_R_WB: begin
          reg_write_o = 1'b1;
          reg_dst_o   = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a_o     = 1'b1;
          alu_op_o        = 3'b010;
          pc_write_cond_o = 1'b1;
          pc_source_o     = 2'b01;
          branch_ne_o     = opcode_i[0];
        end
        S_JUMP: begin
          pc_write_o  = 1'b1;
          pc_source_o = 2'b10;
        end
        S_EXEC_I: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = 2'b10;
          case (opcode_i)
            OP_ADDI: alu_op_o = 3'b100;
            OP_ORI:  alu_op_o = 3'b101;
            OP_ANDI: alu_op_o = 3'b001;
            OP_LUI:  alu_op_o = 3'b110;
            default: alu_op_o = 3'b000;
          endcase
        end
        S_I_WB: begin
          reg_write_o = 1'b1;
        end
`ifdef MULTICYCLE_JAL_EN
        S_JAL: begin
          pc_write_o  = 1'b1;
          pc_source_o = 2'b10;
          reg_write_o = 1'b1;
          link_o      = 1'b1;
        end
`endif
        default: begin
          state_o = state_q;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: directed scenarios followed
// by a randomized instruction stream with random memory stalls. Expectations
// come from per-instruction state paths and a per-state control table.
// Build with MULTICYCLE_JAL_EN defined to cover the JAL state and link_o.
module tb_multicycle_control_fsm;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       link;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
    logic       illegal;
  } ctl_t;

  typedef logic [3:0] path_t[$];

  // clock / reset
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] opcode_i = 6'd0;
  logic       mem_ready_i = 1'b0;
  always #5 clk = ~clk;

  logic       pc_write_o, pc_write_cond_o, branch_ne_o, i_or_d_o;
  logic       mem_read_o, mem_write_o, ir_write_o, mem_to_reg_o;
  logic       reg_dst_o, reg_write_o, alu_src_a_o, illegal_op_o, link_o;
  logic [1:0] alu_src_b_o, pc_source_o;
  logic [2:0] alu_op_o;
  logic [3:0] state_o;

  int   checks = 0;
  int   failures = 0;
  ctl_t tbl[16];

  multicycle_control_fsm dut (
    .clk            (clk),
    .reset          (reset),
    .opcode_i       (opcode_i),
    .mem_ready_i    (mem_ready_i),
    .pc_write_o     (pc_write_o),
    .pc_write_cond_o(pc_write_cond_o),
    .branch_ne_o    (branch_ne_o),
    .i_or_d_o       (i_or_d_o),
    .mem_read_o     (mem_read_o),
    .mem_write_o    (mem_write_o),
    .ir_write_o     (ir_write_o),
    .mem_to_reg_o   (mem_to_reg_o),
    .reg_dst_o      (reg_dst_o),
    .reg_write_o    (reg_write_o),
    .alu_src_a_o    (alu_src_a_o),
    .alu_src_b_o    (alu_src_b_o),
    .pc_source_o    (pc_source_o),
    .alu_op_o       (alu_op_o),
    .illegal_op_o   (illegal_op_o),
`ifdef MULTICYCLE_JAL_EN
    .link_o         (link_o),
`endif
    .state_o        (state_o)
  );

`ifndef MULTICYCLE_JAL_EN
  assign link_o = 1'b0;
`endif

  // Instruction classes as sequences of visited states.
  function automatic path_t path_for(input logic [5:0] opc);
    case (opc)
      6'b100011: return '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
      6'b101011: return '{4'd0, 4'd1, 4'd2, 4'd5};
      6'b000000: return '{4'd0, 4'd1, 4'd6, 4'd7};
      6'b000100, 6'b000101: return '{4'd0, 4'd1, 4'd8};
      6'b000010: return '{4'd0, 4'd1, 4'd9};
      6'b001000, 6'b001101, 6'b001100, 6'b001111: return '{4'd0, 4'd1, 4'd10, 4'd11};
`ifdef MULTICYCLE_JAL_EN
      6'b000011: return '{4'd0, 4'd1, 4'd12};
`endif
      default: return '{4'd0, 4'd1};
    endcase
  endfunction

  function automatic logic [2:0] imm_alu_code(input logic [5:0] opc);
    case (opc)
      6'b001000: return 3'b100;
      6'b001101: return 3'b101;
      6'b001100: return 3'b001;
      6'b001111: return 3'b110;
      default:   return 3'b000;
    endcase
  endfunction

  // Static per-state table plus the few input-dependent fields.
  function automatic ctl_t exp_ctl(input logic [3:0] st, input logic [5:0] opc, input logic rdy);
    path_t p;
    ctl_t  c;
    c = tbl[st];
    p = path_for(opc);
    if (st == 4'd0) begin
      c.ir_write = rdy;
      c.pc_write = rdy;
    end
    if (st == 4'd1)  c.illegal = (p.size() == 2);
    if (st == 4'd8)  c.branch_ne = opc[0];
    if (st == 4'd10) c.alu_op = imm_alu_code(opc);
    return c;
  endfunction

  task automatic init_table();
    foreach (tbl[i]) tbl[i] = '0;
    tbl[0].mem_read = 1'b1;  tbl[0].alu_src_b = 2'b01; tbl[0].alu_op = 3'b011;
    tbl[1].alu_src_b = 2'b11; tbl[1].alu_op = 3'b011;
    tbl[2].alu_src_a = 1'b1; tbl[2].alu_src_b = 2'b10; tbl[2].alu_op = 3'b011;
    tbl[3].mem_read = 1'b1;  tbl[3].i_or_d = 1'b1;
    tbl[4].reg_write = 1'b1; tbl[4].mem_to_reg = 1'b1;
    tbl[5].mem_write = 1'b1; tbl[5].i_or_d = 1'b1;
    tbl[6].alu_src_a = 1'b1; tbl[6].alu_op = 3'b111;
    tbl[7].reg_write = 1'b1; tbl[7].reg_dst = 1'b1;
    tbl[8].alu_src_a = 1'b1; tbl[8].alu_op = 3'b010;
    tbl[8].pc_write_cond = 1'b1; tbl[8].pc_source = 2'b01;
    tbl[9].pc_write = 1'b1;  tbl[9].pc_source = 2'b10;
    tbl[10].alu_src_a = 1'b1; tbl[10].alu_src_b = 2'b10;
    tbl[11].reg_write = 1'b1;
    tbl[12].pc_write = 1'b1; tbl[12].pc_source = 2'b10;
    tbl[12].reg_write = 1'b1; tbl[12].link = 1'b1;
  endtask

  function automatic ctl_t observed();
    return {pc_write_o, pc_write_cond_o, branch_ne_o, i_or_d_o, mem_read_o,
            mem_write_o, ir_write_o, mem_to_reg_o, reg_dst_o, reg_write_o,
            link_o, alu_src_a_o, alu_src_b_o, pc_source_o, alu_op_o, illegal_op_o};
  endfunction

  // Driver: apply inputs after the rising edge, compare at the falling edge.
  task automatic check_cycle(input logic [3:0] st, input logic [5:0] opc,
                             input logic rdy, input logic in_reset, input string tag);
    ctl_t exp_c;
    ctl_t got_c;
    opcode_i    = opc;
    mem_ready_i = rdy;
    @(negedge clk);
    exp_c = in_reset ? '0 : exp_ctl(st, opc, rdy);
    got_c = observed();
    checks++;
    assert (state_o === (in_reset ? 4'd0 : st))
    else begin
      failures++;
      $error("FAIL %s state: observed %0d expected %0d", tag, state_o, in_reset ? 4'd0 : st);
    end
    checks++;
    assert (got_c === exp_c)
    else begin
      failures++;
      $error("FAIL %s ctl (state %0d op %b rdy %b): observed %h expected %h",
             tag, st, opc, rdy, got_c, exp_c);
    end
    @(posedge clk);
    #1;
  endtask

  // Walk one instruction along its path, with random stalls in memory states.
  task automatic run_instr(input logic [5:0] opc, input int max_stall, input string tag);
    path_t p;
    logic  rdy;
    int    n;
    p = path_for(opc);
    foreach (p[i]) begin
      if (p[i] == 4'd0 || p[i] == 4'd3 || p[i] == 4'd5) begin
        n = 0;
        do begin
          rdy = (n >= max_stall) ? 1'b1 : 1'($urandom_range(0, 1));
          check_cycle(p[i], opc, rdy, 1'b0, tag);
          n++;
        end while (!rdy);
      end else begin
        check_cycle(p[i], opc, 1'($urandom_range(0, 1)), 1'b0, tag);
      end
    end
  endtask

  // Instruction length with memory always ready, bounded at 20 cycles.
  task automatic count_cycles(input logic [5:0] opc, input int expected, input string tag);
    int n;
    opcode_i    = opc;
    mem_ready_i = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (state_o !== 4'd0 && n < 20);
    checks++;
    assert (n === expected)
    else begin
      failures++;
      $error("FAIL %s cycles: observed %0d expected %0d", tag, n, expected);
    end
  endtask

  logic [5:0] pool[12];
  logic [5:0] opc_r;

  initial begin
    init_table();
    pool = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101, 6'b000010,
             6'b001000, 6'b001101, 6'b001100, 6'b001111, 6'b000011, 6'b111111};
    @(posedge clk);
    #1;

    // Reset held two cycles, then FETCH stalls until memory is ready.
    reset = 1'b0;
    check_cycle(4'd0, 6'b100011, 1'b1, 1'b1, "reset0");
    check_cycle(4'd0, 6'b100011, 1'b1, 1'b1, "reset1");
    reset = 1'b1;
    check_cycle(4'd0, 6'b100011, 1'b0, 1'b0, "stall0");
    check_cycle(4'd0, 6'b100011, 1'b0, 1'b0, "stall1");
    check_cycle(4'd0, 6'b100011, 1'b1, 1'b0, "fetch_go");
    check_cycle(4'd1, 6'b100011, 1'b1, 1'b0, "lw");
    check_cycle(4'd2, 6'b100011, 1'b1, 1'b0, "lw");
    check_cycle(4'd3, 6'b100011, 1'b1, 1'b0, "lw");
    check_cycle(4'd4, 6'b100011, 1'b1, 1'b0, "lw");

    // Directed instruction classes.
    run_instr(6'b000000, 0, "rtype");
    run_instr(6'b001101, 0, "ori");
    run_instr(6'b000101, 0, "bne");
    run_instr(6'b000100, 0, "beq");
    run_instr(6'b111111, 0, "illegal");
    run_instr(6'b000011, 0, "jal");
    run_instr(6'b101011, 2, "sw");

    // Reset while MEM_WRITE waits on memory.
    check_cycle(4'd0, 6'b101011, 1'b1, 1'b0, "sw_rst");
    check_cycle(4'd1, 6'b101011, 1'b1, 1'b0, "sw_rst");
    check_cycle(4'd2, 6'b101011, 1'b1, 1'b0, "sw_rst");
    check_cycle(4'd5, 6'b101011, 1'b0, 1'b0, "sw_rst");
    reset = 1'b0;
    check_cycle(4'd5, 6'b101011, 1'b0, 1'b1, "rst_in_memwrite");
    reset = 1'b1;
    check_cycle(4'd0, 6'b101011, 1'b0, 1'b0, "after_rst");
    check_cycle(4'd0, 6'b101011, 1'b1, 1'b0, "after_rst");
    check_cycle(4'd1, 6'b000000, 1'b1, 1'b0, "after_rst");
    check_cycle(4'd6, 6'b000000, 1'b1, 1'b0, "after_rst");
    check_cycle(4'd7, 6'b000000, 1'b1, 1'b0, "after_rst");

    // Instruction lengths with memory always ready.
    count_cycles(6'b100011, 5, "len_lw");
    count_cycles(6'b101011, 4, "len_sw");
    count_cycles(6'b000000, 4, "len_r");
    count_cycles(6'b001000, 4, "len_addi");
    count_cycles(6'b000100, 3, "len_beq");
    count_cycles(6'b000010, 3, "len_j");
`ifdef MULTICYCLE_JAL_EN
    count_cycles(6'b000011, 3, "len_jal");
`else
    count_cycles(6'b000011, 2, "len_jal_illegal");
`endif

    // Randomized instruction stream with random memory stalls.
    for (int k = 0; k < 200; k++) begin
      opc_r = pool[$urandom_range(0, 11)];
      if ($urandom_range(0, 7) == 0) opc_r = 6'($urandom_range(0, 63));
      run_instr(opc_r, 3, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Main control unit for the multicycle MIPS datapath and the producer of the 3-bit alu_op code consumed by the ALU control decoder.
- Sequences each instruction through fetch, decode, execute, memory and write-back states.
- Drives all datapath mux selects and write enables, and stalls on a memory ready handshake.
- Emits alu_op codes in the decoder's encoding so the ALU operation follows directly from state and opcode.

Parameters:
- RESET_STATE, 4'd0, state entered on reset (FETCH); kept for bench override only.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-low reset
- opcode_i  input  6  instruction[31:26] from instruction register
- mem_ready_i  input  1  memory completes current access this cycle
- pc_write_o  output  1  unconditional PC write
- pc_write_cond_o  output  1  PC write if branch condition true
- branch_ne_o  output  1  1 = condition is not-zero (bne), 0 = zero (beq)
- i_or_d_o  output  1  memory address select: 0 PC, 1 ALUOut
- mem_read_o  output  1  memory read request
- mem_write_o  output  1  memory write request
- ir_write_o  output  1  instruction register load
- mem_to_reg_o  output  1  write-back data: 0 ALUOut, 1 MDR
- reg_dst_o  output  1  destination: 0 rt, 1 rd
- reg_write_o  output  1  register file write
- alu_src_a_o  output  1  0 PC, 1 register A
- alu_src_b_o  output  2  00 reg B, 01 const 4, 10 extended imm, 11 imm<<2
- pc_source_o  output  2  00 ALU result, 01 ALUOut, 10 jump target
- alu_op_o  output  3  code to ALU control decoder
- illegal_op_o  output  1  one-cycle pulse on unknown opcode
- state_o  output  4  current state, for debug and bench

Behaviour:
- Moore FSM; all outputs decoded from registered state only. Exception: FETCH pc_write_o, ir_write_o and MEM_READ completion are gated by mem_ready_i.
- reset low at a rising edge -> state FETCH. Applies even mid-instruction: any pending access is abandoned and no write-enable asserts in that cycle.
- Output values during reset: all 1-bit outputs 0, selects 0, alu_op_o 3'b000.
- Unless listed for a state, outputs are 0 and alu_op_o = 000.
- alu_op codes: 111 R-type, 100 addi, 101 ori, 001 andi, 110 lui, 011 add (lw/sw/PC+4/branch target), 010 subtract (beq/bne).
- FETCH(0): mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=011, pc_source=00. ir_write and pc_write = mem_ready_i. Stay until mem_ready_i=1, then DECODE.
- DECODE(1): alu_src_a=0, alu_src_b=11, alu_op=011 (branch target into ALUOut). Next state by opcode:
  - 100011 lw or 101011 sw -> MEM_ADDR
  - 000000 -> EXEC_R
  - 000100 or 000101 -> BRANCH
  - 000010 -> JUMP
  - 001000, 001101, 001100, 001111 -> EXEC_I
  - anything else -> FETCH, with illegal_op_o=1 in this DECODE cycle.
- MEM_ADDR(2): alu_src_a=1, alu_src_b=10, alu_op=011 -> MEM_READ if lw, MEM_WRITE if sw.
- MEM_READ(3): mem_read=1, i_or_d=1. Stay until mem_ready_i, then MEM_WB.
- MEM_WB(4): reg_write=1, mem_to_reg=1, reg_dst=0 -> FETCH.
- MEM_WRITE(5): mem_write=1, i_or_d=1. Stay until mem_ready_i, then FETCH.
- EXEC_R(6): alu_src_a=1, alu_src_b=00, alu_op=111 -> R_WB.
- R_WB(7): reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
- BRANCH(8): alu_src_a=1, alu_src_b=00, alu_op=010, pc_write_cond=1, pc_source=01, branch_ne = opcode_i[0] -> FETCH.
- JUMP(9): pc_write=1, pc_source=10 -> FETCH.
- EXEC_I(10): alu_src_a=1, alu_src_b=10, alu_op by opcode (100/101/001/110) -> I_WB.
- I_WB(11): reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH.
- Unused state encodings -> FETCH next cycle, all outputs 0.
- opcode_i must be stable from DECODE to instruction end; the FSM samples it in every state.
- Cycle counts with mem_ready_i tied high:
  - lw 5
  - sw, R-type, I-type 4
  - beq, bne, j 3

Optional Feature:
- Macro: MULTICYCLE_JAL_EN.
- Defined: opcode 000011 in DECODE -> state JAL(12). JAL drives:
  - pc_write=1, pc_source=10
  - reg_write=1; an additional output link_o=1 selects $ra as destination and PC as write data
  - then -> FETCH.
- Undefined: port link_o is absent, and 000011 is treated as illegal (illegal_op_o pulse, return to FETCH).

Test Plan:
- Reset and stall: reset low 2 cycles, release with mem_ready_i=0 -> state_o=0 held, pc_write_o=0, ir_write_o=0. Raise mem_ready_i for 1 cycle -> pc_write_o=ir_write_o=1 that cycle, then state_o=1.
- lw (100011) with mem_ready_i=1 -> states 0,1,2,3,4,0. In state 4, reg_write_o=1 and mem_to_reg_o=1. alu_op_o=011 in states 0,1,2.
- R-type (000000) -> state 6 alu_op_o=111; state 7 reg_write_o=1 and reg_dst_o=1. ori (001101) -> state 10 alu_op_o=101.
- bne (000101) -> state 8 with pc_write_cond_o=1, branch_ne_o=1, alu_op_o=010, pc_source_o=01. beq (000100) -> branch_ne_o=0.
- Illegal opcode 111111 -> illegal_op_o one-cycle pulse in state 1, next state 0, no write enables asserted.
- Reset low during MEM_WRITE with mem_ready_i=0 -> next cycle state_o=0, mem_write_o=0. With MULTICYCLE_JAL_EN, jal (000011) -> states 0,1,12,0 with link_o=1 and pc_write_o=1 in state 12.
